// File: rtl/i2c_target_regs_if.sv
// Open-drain I2C pin bundle between the bus model/pads and the register target.
interface i2c_target_regs_if;
    logic scl_i;
    logic sda_i;
    logic sda_o;
    logic sda_oen_o;

    modport slave  (input scl_i, input sda_i, output sda_o, output sda_oen_o);
    modport master (output scl_i, output sda_i, input sda_o, input sda_oen_o);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte register file: pointer write, auto-incrementing
// burst write/read, oversampled pins in the PCLK domain, no clock stretching.
module i2c_target_regs #(
    parameter logic [6:0] ADDR  = 7'h42,
    parameter int         DEPTH = 16,
    parameter int         AW    = 4
) (
    input  logic          PCLK,
    input  logic          RESET,
    i2c_target_regs_if.slave bus,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          wr_pulse,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_IGNORE, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
    } state_t;

    state_t        state_q;
    logic          scl_s1_q, scl_s2_q, scl_d_q;
    logic          sda_s1_q, sda_s2_q, sda_d_q;
    logic [AW-1:0] ptr_q;
    logic [7:0]    sr_q;
    logic [3:0]    cnt_q;
    logic          ack_drv_q;
    logic          sda_q;
    logic          busy_q;
    logic          wr_pulse_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    wr_data_q;
    logic [7:0]    regs_q [DEPTH];

    logic       scl_rise, scl_fall, start_det, stop_det, byte_done;
    logic [7:0] byte_d;

    always_comb begin
        scl_rise  = scl_s2_q & ~scl_d_q;
        scl_fall  = ~scl_s2_q & scl_d_q;
        // SCL must be high on both samples so an SDA move right at an SCL edge is not a bus condition
        start_det = scl_s2_q & scl_d_q & ~sda_s2_q & sda_d_q;
        stop_det  = scl_s2_q & scl_d_q & sda_s2_q & ~sda_d_q;
        byte_d    = {sr_q[6:0], sda_s2_q};
        byte_done = scl_rise && (cnt_q == 4'd7);
    end

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_d_q <= 1'b1;
            sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_d_q <= 1'b1;
        end else begin
            scl_s1_q <= bus.scl_i; scl_s2_q <= scl_s1_q; scl_d_q <= scl_s2_q;
            sda_s1_q <= bus.sda_i; sda_s2_q <= sda_s1_q; sda_d_q <= sda_s2_q;
        end
    end

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            sr_q       <= '0;
            cnt_q      <= '0;
            ack_drv_q  <= 1'b0;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_pulse_q <= 1'b0;
            if (start_det) begin
                state_q <= S_ADDR;
                cnt_q   <= '0;
                sda_q   <= 1'b1;
            end else if (stop_det) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                sda_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_ADDR: if (scl_rise) begin
                        sr_q  <= byte_d;
                        cnt_q <= cnt_q + 4'd1;
                        if (byte_done) begin
                            ack_drv_q <= 1'b0;
                            if (byte_d[7:1] == ADDR) begin
                                state_q <= S_ADDR_ACK;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= S_IGNORE;
                            end
                        end
                    end
                    S_PTR: if (scl_rise) begin
                        sr_q  <= byte_d;
                        cnt_q <= cnt_q + 4'd1;
                        if (byte_done) begin
                            ack_drv_q <= 1'b0;
                            ptr_q     <= byte_d[AW-1:0];
                            state_q   <= S_PTR_ACK;
                        end
                    end
                    S_WDATA: if (scl_rise) begin
                        sr_q  <= byte_d;
                        cnt_q <= cnt_q + 4'd1;
                        if (byte_done) begin
                            ack_drv_q  <= 1'b0;
                            wr_pulse_q <= 1'b1;
                            wr_addr_q  <= ptr_q;
                            wr_data_q  <= byte_d;
                            ptr_q      <= ptr_q + 1'b1;
                            state_q    <= S_WDATA_ACK;
                        end
                    end
                    // First falling edge starts the ACK slot, the second one ends it
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                        if (!ack_drv_q) begin
                            ack_drv_q <= 1'b1;
                            sda_q     <= 1'b0;
                        end else begin
                            ack_drv_q <= 1'b0;
                            cnt_q     <= '0;
                            sda_q     <= 1'b1;
                            if (state_q == S_ADDR_ACK && sr_q[0]) begin
                                state_q <= S_RDATA;
                                sr_q    <= regs_q[ptr_q];
                                sda_q   <= regs_q[ptr_q][7];
                            end else if (state_q == S_ADDR_ACK) begin
                                state_q <= S_PTR;
                            end else begin
                                state_q <= S_WDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) begin
                            cnt_q <= cnt_q + 4'd1;
                            if (cnt_q == 4'd7) ptr_q <= ptr_q + 1'b1;
                        end else if (scl_fall) begin
                            if (cnt_q == 4'd8) begin
                                state_q <= S_RDATA_ACK;
                                sda_q   <= 1'b1;
                            end else begin
                                sda_q <= sr_q[6];
                                sr_q  <= {sr_q[6:0], 1'b0};
                            end
                        end
                    end
                    // sr_q[0] holds the master's ACK/NACK bit until the slot ends
                    S_RDATA_ACK: begin
                        if (scl_rise) begin
                            sr_q[0] <= sda_s2_q;
                        end else if (scl_fall) begin
                            if (!sr_q[0]) begin
                                state_q <= S_RDATA;
                                cnt_q   <= '0;
                                sr_q    <= regs_q[ptr_q];
                                sda_q   <= regs_q[ptr_q][7];
                            end else begin
                                state_q <= S_IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The register update lands one cycle after wr_pulse, so a local read during the pulse sees the old byte
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_pulse_q) begin
            regs_q[wr_addr_q] <= wr_data_q;
        end
    end

    assign rd_data       = regs_q[rd_addr];
    assign wr_pulse      = wr_pulse_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign busy          = busy_q;
    assign bus.sda_o     = sda_q;
    assign bus.sda_oen_o = sda_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master driving the register target on a wired-AND SDA, checked
// against a register-array/pointer model of the transaction rules.
module tb_i2c_target_regs;
    localparam logic [6:0] ADDR  = 7'h42;
    localparam int         DEPTH = 16;
    localparam int         AW    = 4;
    localparam int         Q     = 6;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          m_scl = 1'b1;
    logic          m_sda = 1'b1;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          wr_pulse;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  model_regs [DEPTH];
    int          model_ptr;
    logic [11:0] exp_wr [$];
    logic [11:0] act_wr [$];
    int          wr_seen = 0;
    logic [7:0]  tx_q [$];

    int          low_cnt  = 0;
    int          snap_cnt = 0;
    logic        snap_arm = 1'b0;
    logic [7:0]  snap_old = '0;
    logic [7:0]  snap_new = '0;

    i2c_target_regs_if bus ();
    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & bus.sda_o;

    i2c_target_regs #(.ADDR(ADDR), .DEPTH(DEPTH), .AW(AW)) dut (
        .PCLK     (clk),
        .RESET    (rst),
        .bus      (bus.slave),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run reached 95000 cycles, required to finish earlier");
        $fatal(1);
    end

    // Passive monitor: target drive activity, write events and same-cycle local reads
    always @(negedge clk) begin
        if (bus.sda_o === 1'b0) low_cnt++;
        if (snap_arm) begin
            snap_new = rd_data;
            snap_arm = 1'b0;
        end
        if (wr_pulse === 1'b1) begin
            act_wr.push_back({wr_addr, wr_data});
            if (wr_addr == rd_addr) begin
                snap_old = rd_data;
                snap_arm = 1'b1;
                snap_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop;
        m_scl = 1'b0;
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic i2c_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            m_sda = b[i]; wait_clk(Q);
            m_scl = 1'b1; wait_clk(2 * Q);
            m_scl = 1'b0; wait_clk(Q);
        end
    endtask

    task automatic i2c_wr_byte(input logic [7:0] b, output logic ack);
        i2c_bits(b, 8);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        ack = bus.sda_i; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_rd_byte(output logic [7:0] b, input logic nack);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q);
            m_scl = 1'b1; wait_clk(Q);
            b[i] = bus.sda_i; wait_clk(Q);
            m_scl = 1'b0; wait_clk(Q);
        end
        m_sda = nack; wait_clk(Q);
        m_scl = 1'b1; wait_clk(2 * Q);
        m_scl = 1'b0; wait_clk(Q);
        m_sda = 1'b1;
    endtask

    task automatic check_wr;
        chk("wr_count", act_wr.size(), exp_wr.size());
        for (int i = wr_seen; i < exp_wr.size() && i < act_wr.size(); i++)
            chk("wr_event", act_wr[i], exp_wr[i]);
        wr_seen = exp_wr.size();
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            wait_clk(1);
            chk(tag, rd_data, model_regs[a]);
        end
    endtask

    task automatic model_clear;
        for (int a = 0; a < DEPTH; a++) model_regs[a] = 8'h00;
        model_ptr = 0;
    endtask

    // Pointer byte p, then every byte of tx_q written at successive addresses
    task automatic do_write(input logic [7:0] p);
        logic ack;
        i2c_start;
        i2c_wr_byte({ADDR, 1'b0}, ack); chk("w_addr_ack", ack, 0);
        i2c_wr_byte(p, ack);            chk("w_ptr_ack", ack, 0);
        model_ptr = int'(p) % DEPTH;
        foreach (tx_q[i]) begin
            i2c_wr_byte(tx_q[i], ack); chk("w_data_ack", ack, 0);
            exp_wr.push_back({AW'(model_ptr), tx_q[i]});
            model_regs[model_ptr] = tx_q[i];
            model_ptr = (model_ptr + 1) % DEPTH;
        end
        chk("w_busy", busy, 1);
        i2c_stop;
        chk("w_busy_stop", busy, 0);
        check_wr();
    endtask

    task automatic do_read(input int n, input bit set_ptr, input logic [7:0] p);
        logic ack;
        logic [7:0] d;
        i2c_start;
        if (set_ptr) begin
            i2c_wr_byte({ADDR, 1'b0}, ack); chk("r_waddr_ack", ack, 0);
            i2c_wr_byte(p, ack);            chk("r_ptr_ack", ack, 0);
            model_ptr = int'(p) % DEPTH;
            i2c_start;
        end
        i2c_wr_byte({ADDR, 1'b1}, ack); chk("r_addr_ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            i2c_rd_byte(d, 1'(i == n - 1));
            chk("r_data", d, model_regs[model_ptr]);
            model_ptr = (model_ptr + 1) % DEPTH;
        end
        chk("r_sda_released", bus.sda_o, 1);
        chk("r_busy", busy, 1);
        i2c_stop;
        chk("r_busy_stop", busy, 0);
        check_wr();
    endtask

    initial begin
        logic ack;
        int   s0, l0, n;
        model_clear();
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        chk("rst_sda_o", bus.sda_o, 1);
        chk("rst_sda_oen", bus.sda_oen_o, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        sweep("rst_regs");

        // Write burst with a local read watching register 3
        rd_addr = 4'd3; wait_clk(1);
        s0 = snap_cnt;
        tx_q = '{8'hA5, 8'h5A};
        do_write(8'h03);
        chk("same_cycle_hits", snap_cnt - s0, 1);
        chk("same_cycle_old", snap_old, 8'h00);
        chk("next_cycle_new", snap_new, 8'hA5);
        rd_addr = 4'd4; wait_clk(1);
        chk("rd_data_4", rd_data, 8'h5A);

        do_read(2, 1'b1, 8'h03);

        // Foreign address: no ACK, no drive, no writes
        l0 = low_cnt;
        i2c_start;
        i2c_wr_byte(8'hAA, ack); chk("mm_addr_nack", ack, 1);
        chk("mm_busy", busy, 0);
        i2c_wr_byte(8'h00, ack); chk("mm_data_nack", ack, 1);
        i2c_stop;
        chk("mm_no_drive", low_cnt - l0, 0);
        check_wr();

        // Pointer wrap, then a plain read continues at the wrapped pointer
        tx_q = '{8'hC3};
        do_write(8'h01);
        tx_q = '{8'h11, 8'h22};
        do_write(8'h0F);
        rd_addr = 4'd15; wait_clk(1); chk("wrap_r15", rd_data, 8'h11);
        rd_addr = 4'd0;  wait_clk(1); chk("wrap_r0", rd_data, 8'h22);
        do_read(1, 1'b0, 8'h00);

        // STOP after four data bits discards the partial byte
        i2c_start;
        i2c_wr_byte({ADDR, 1'b0}, ack); chk("ab_addr_ack", ack, 0);
        i2c_wr_byte(8'h02, ack);        chk("ab_ptr_ack", ack, 0);
        model_ptr = 2;
        i2c_bits(8'hF0, 4);
        i2c_stop;
        chk("ab_busy", busy, 0);
        check_wr();
        rd_addr = 4'd2; wait_clk(1); chk("ab_r2", rd_data, model_regs[2]);

        for (int it = 0; it < 14; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    tx_q.delete();
                    n = $urandom_range(1, 4);
                    repeat (n) tx_q.push_back(8'($urandom_range(0, 255)));
                    do_write(8'($urandom_range(0, 255)));
                end
                1: do_read($urandom_range(1, 3), 1'b1, 8'($urandom_range(0, 255)));
                default: do_read($urandom_range(1, 3), 1'b0, 8'h00);
            endcase
        end
        sweep("rand_regs");

        // Reset while the target drives a 0 data bit
        tx_q = '{8'h3C};
        do_write(8'h07);
        i2c_start;
        i2c_wr_byte({ADDR, 1'b0}, ack); chk("rr_waddr_ack", ack, 0);
        i2c_wr_byte(8'h07, ack);        chk("rr_ptr_ack", ack, 0);
        i2c_start;
        i2c_wr_byte({ADDR, 1'b1}, ack); chk("rr_raddr_ack", ack, 0);
        chk("rr_bit7_driven", bus.sda_o, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rr_sda_o", bus.sda_o, 1);
        chk("rr_sda_oen", bus.sda_oen_o, 1);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        m_sda = 1'b1; m_scl = 1'b1;
        wait_clk(4 * Q);
        chk("rr_busy", busy, 0);
        sweep("rr_regs");
        do_read(1, 1'b0, 8'h00);
        tx_q = '{8'h99};
        do_write(8'h0A);
        do_read(1, 1'b1, 8'h0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- Synthesizable I2C target (slave) with a small byte register file. It sits directly downstream of APB2I2C on the shared open-drain SCL/SDA pins, and is an on-chip alternative to an external EEPROM target.
- The I2C master writes a register pointer, then writes or reads bytes with pointer auto-increment.
- Register contents are exposed to local logic through a read port and write-event pulses.
- SCL and SDA are oversampled in the PCLK domain. The target never stretches the clock.

Parameters:
- ADDR, 7'h42, 7-bit target address matched in the address phase.
- DEPTH, 16, number of 8-bit registers; power of two, 2..256.
- AW, 4, pointer width; AW = log2(DEPTH).

Ports:
- PCLK  in  1  system clock; must be ≥ 16× the SCL frequency.
- RESET  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL pin level.
- sda_i  in  1  SDA pin level.
- sda_o  out  1  SDA output: 0 = pull low, 1 = release.
- sda_oen_o  out  1  output enable, active-low; equals sda_o (open-drain).
- rd_addr  in  AW  local read address.
- rd_data  out  8  regs[rd_addr], combinational.
- wr_pulse  out  1  one-cycle pulse per byte written by the I2C master.
- wr_addr  out  AW  register written; valid with wr_pulse.
- wr_data  out  8  byte written; valid with wr_pulse.
- busy  out  1  high from an address-matched START until STOP.

Behaviour:
- Synchronisation and edge detection:
  - scl_i and sda_i pass through 2-flop synchronisers, then a third delay flop for edge detection.
  - Every event below is detected 3 PCLK cycles after the pin change.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are honoured in any state; a START seen mid-transfer is a repeated START and goes to ADDR.
  - STOP → IDLE; any partial byte is discarded.
- Bit timing:
  - Input bits are sampled on the detected SCL rising edge.
  - sda_o changes only on the cycle after a detected SCL falling edge.
- State machine:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits, MSB first.
    - If bits[7:1] == ADDR → ADDR_ACK.
    - Otherwise → IGNORE; no drive until the next START or STOP.
  - ADDR_ACK: drive 0 for one SCL period.
    - R/W = 0 → PTR.
    - R/W = 1 → load the shift register from regs[ptr], then → RDATA.
  - PTR: receive 8 bits; ptr ← byte[AW-1:0] (upper bits ignored); → PTR_ACK → WDATA.
  - WDATA: receive a byte, then:
    - regs[ptr] ← byte, with wr_pulse/wr_addr/wr_data driven in the same cycle;
    - ptr ← ptr + 1;
    - → WDATA_ACK (drive 0) → WDATA.
  - RDATA:
    - drive 8 bits MSB first; bit 7 is driven from the falling edge that ends ACK;
    - ptr ← ptr + 1 after bit 0;
    - → RDATA_ACK, releasing SDA.
  - RDATA_ACK: sample the master's bit.
    - 0 (ACK) → reload from regs[ptr] → RDATA.
    - 1 (NACK) → IGNORE.
- ACK release: SDA released on the SCL falling edge that ends any ACK slot.
- Pointer:
  - Wraps modulo DEPTH.
  - Persists across transactions, so a write of only the pointer followed by a repeated-START read reads from that pointer.
- Arbitration: sda_o = 1 whenever state ∉ {ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA}.
- Reset (any state, including mid-byte):
  - sda_o = 1, sda_oen_o = 1 on the next PCLK edge;
  - state = IDLE, ptr = 0, all regs = 8'h00;
  - wr_pulse = 0, wr_addr = 0, wr_data = 0, busy = 0;
  - synchroniser flops = 1.
- Simultaneous events: a local rd_addr read in the same cycle as a bus write to the same register returns the old value; the new value is visible next cycle.

Test Plan:
- Write burst: START, 0x84, 0x03, 0xA5, 0x5A, STOP →
  - four ACKs from target;
  - regs[3] = A5, regs[4] = 5A;
  - two wr_pulses with (3, A5) then (4, 5A);
  - rd_addr = 4 → rd_data = 5A.
- Read with repeated START: START, 0x84, 0x03, Sr, 0x85, read 2 bytes (ACK, NACK), STOP →
  - SDA bytes A5, 5A;
  - SDA released after NACK;
  - busy falls at STOP.
- Address mismatch: START, 0xAA (0x55 write), 0x00, STOP →
  - sda_o = 1 throughout;
  - NACK on the bus;
  - no wr_pulse, busy = 0.
- Pointer wrap: write ptr 0x0F, then data 0x11, 0x22 → regs[15] = 11, regs[0] = 22, ptr = 1.
- Abort cases:
  - STOP after 4 data bits → no write, IDLE;
  - RESET asserted while driving a read bit → sda_o = 1 next cycle, regs cleared.
- System: APB2I2C + this block on tri1 pins, PCLK = 10 MHz, prescale 25 → the APB write/read sequence returns the written bytes from the PRDATA FIFO.
